// File: rtl/sent_tx_frame_packer_if.sv
// Handshake and FIFO signals between the SENT TX frame packer and its environment.
interface sent_tx_frame_packer_if;
    logic        frame_req;
    logic [2:0]  load_bit;
    logic        busy;
    logic        done;
    logic [15:0] data_f1;
    logic [11:0] data_f2;
    logic        underflow;
    logic        underflow_clr;
    logic [11:0] data_in;
    logic        fifo_tx_empty;
    logic        read_enable_tx;

    modport master (
        output frame_req, load_bit, underflow_clr, data_in, fifo_tx_empty,
        input  busy, done, data_f1, data_f2, underflow, read_enable_tx
    );

    modport slave (
        input  frame_req, load_bit, underflow_clr, data_in, fifo_tx_empty,
        output busy, done, data_f1, data_f2, underflow, read_enable_tx
    );
endinterface

// File: rtl/sent_tx_frame_packer.sv
// SENT TX data stage: paced fetch of one or two FIFO words and packing into data_f1/data_f2.
// Define SENT_TX_UNDERFLOW_HOLD_EN to repeat the last popped word per slot on FIFO underflow.
module sent_tx_frame_packer #(
    parameter int unsigned FETCH_GAP      = 6,
    parameter logic [11:0] UNDERFLOW_FILL = 12'h000
) (
    input logic                   clk_tx,
    input logic                   reset_tx,
    sent_tx_frame_packer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StGap, StPop, StPack} state_e;

    state_e      state_q, state_d;
    logic [2:0]  fmt_q, fmt_d;
    logic        two_q, two_d;
    logic        slot_q, slot_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [11:0] w1_q, w1_d;
    logic [15:0] f1_q, f1_d;
    logic [11:0] f2_q, f2_d;
    logic        uf_q, uf_d;
    logic        accept;
    logic [11:0] fill_word, slot_word, w1_pk, w2_pk;

    if (FETCH_GAP < 2 || FETCH_GAP > 31) begin : g_gap_check
        $error("FETCH_GAP must be in 2..31");
    end

`ifdef SENT_TX_UNDERFLOW_HOLD_EN
    logic [1:0][11:0] hold_q;
    logic [1:0]       hold_vld_q;

    assign fill_word = hold_vld_q[slot_q] ? hold_q[slot_q] : UNDERFLOW_FILL;

    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            hold_q     <= '0;
            hold_vld_q <= '0;
        end else if (state_q == StPop && !bus.fifo_tx_empty) begin
            hold_q[slot_q]     <= bus.data_in;
            hold_vld_q[slot_q] <= 1'b1;
        end
    end
`else
    assign fill_word = UNDERFLOW_FILL;
`endif

    assign slot_word = bus.fifo_tx_empty ? fill_word : bus.data_in;
    // The done cycle doubles as idle so back-to-back requests lose no cycle.
    assign accept    = bus.frame_req && (bus.load_bit != 3'b000) &&
                       (state_q == StIdle || state_q == StPack);
    assign w1_pk     = two_q ? w1_q : slot_word;
    assign w2_pk     = two_q ? slot_word : 12'h000;

    always_comb begin
        state_d = state_q;
        fmt_d   = fmt_q;
        two_d   = two_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        w1_d    = w1_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        uf_d    = uf_q & ~bus.underflow_clr;
        unique case (state_q)
            StIdle, StPack: begin
                state_d = StIdle;
                if (accept) begin
                    fmt_d   = bus.load_bit;
                    two_d   = (bus.load_bit == 3'b001) || (bus.load_bit[2:1] == 2'b11);
                    slot_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == 5'(FETCH_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = StPop;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StPop: begin
                if (bus.fifo_tx_empty) begin
                    uf_d = 1'b1;
                end
                if (two_q && !slot_q) begin
                    w1_d    = slot_word;
                    slot_d  = 1'b1;
                    state_d = StGap;
                end else begin
                    // Outputs are registered on entry to PACK so they are valid with done.
                    state_d = StPack;
                    case (fmt_q)
                        3'b110: begin
                            f1_d = {2'b00, w1_pk, w2_pk[11:10]};
                            f2_d = {2'b00, w2_pk[9:0]};
                        end
                        3'b111: begin
                            f1_d = {w1_pk, w2_pk[11:8]};
                            f2_d = {4'h0, w2_pk[7:0]};
                        end
                        default: begin
                            f1_d = {4'h0, w1_pk};
                            f2_d = w2_pk;
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            state_q <= StIdle;
            fmt_q   <= '0;
            two_q   <= 1'b0;
            slot_q  <= 1'b0;
            cnt_q   <= '0;
            w1_q    <= '0;
            f1_q    <= '0;
            f2_q    <= '0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            two_q   <= two_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            w1_q    <= w1_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.busy           = (state_q == StGap) || (state_q == StPop);
    assign bus.done           = (state_q == StPack);
    assign bus.read_enable_tx = (state_q == StPop) && !bus.fifo_tx_empty;
    assign bus.data_f1        = f1_q;
    assign bus.data_f2        = f2_q;
    assign bus.underflow      = uf_q;
endmodule

// File: tb/tb_sent_tx_frame_packer.sv
// Self-checking bench for sent_tx_frame_packer: vector table, corner sequences, random frames.
module tb_sent_tx_frame_packer;
    localparam int unsigned FG   = 6;
    localparam logic [11:0] FILL = 12'h000;
`ifdef SENT_TX_UNDERFLOW_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk_tx = 1'b0;
    logic reset_tx;

    sent_tx_frame_packer_if bus ();

    sent_tx_frame_packer #(
        .FETCH_GAP      (FG),
        .UNDERFLOW_FILL (FILL)
    ) dut (
        .clk_tx   (clk_tx),
        .reset_tx (reset_tx),
        .bus      (bus)
    );

    always #5 clk_tx = ~clk_tx;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    logic [11:0] fifo [$];
    logic [11:0] hist [2];
    bit          hist_v [2];
    logic [15:0] last_f1 = '0;
    logic [11:0] last_f2 = '0;

    typedef struct {
        logic [2:0]  fmt;
        int          nwords;
        logic [11:0] wa;
        logic [11:0] wb;
        logic [15:0] f1;
        logic [11:0] f2;
        bit          uf;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_tx_empty = (fifo.size() == 0);
        bus.data_in       = (fifo.size() != 0) ? fifo[0] : 12'($urandom);
    endtask

    // One clock: sample the pop strobe mid-cycle, then apply it to the FIFO model after the edge.
    task automatic step();
        logic re;
        re = bus.read_enable_tx;
        @(posedge clk_tx);
        #1;
        if (re) begin
            n_pops++;
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        drive_fifo();
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 2; k++) begin
            hist[k]   = '0;
            hist_v[k] = 1'b0;
        end
    endtask

    // Reference: words taken in order from the FIFO, empty slots filled, fields by arithmetic.
    task automatic model_frame(input logic [2:0] fmt, output logic [15:0] f1,
                               output logic [11:0] f2, output int nw, output bit [1:0] got);
        logic [11:0] w [2];
        int idx;
        int a, b;
        idx = 0;
        got = 2'b00;
        nw  = (fmt == 3'd1 || fmt == 3'd6 || fmt == 3'd7) ? 2 : 1;
        w[0] = '0;
        w[1] = '0;
        for (int k = 0; k < nw; k++) begin
            if (idx < fifo.size()) begin
                w[k]      = fifo[idx];
                idx++;
                got[k]    = 1'b1;
                hist[k]   = w[k];
                hist_v[k] = 1'b1;
            end else begin
                w[k] = (HOLD && hist_v[k]) ? hist[k] : FILL;
            end
        end
        a = int'(w[0]);
        b = int'(w[1]);
        case (fmt)
            3'd1:    begin f1 = 16'(a);              f2 = 12'(b);        end
            3'd6:    begin f1 = 16'(a * 4 + b / 1024); f2 = 12'(b % 1024); end
            3'd7:    begin f1 = 16'(a * 16 + b / 256); f2 = 12'(b % 256);  end
            default: begin f1 = 16'(a);              f2 = 12'h000;       end
        endcase
    endtask

    task automatic run_frame(input string tag, input logic [2:0] fmt, input logic [15:0] ef1,
                             input logic [11:0] ef2, input int nw, input bit [1:0] got,
                             input bit exp_uf, input bit noise);
        int         dc;
        logic [2:0] exp_ctl;
        dc = nw * (FG + 1) + 1;
        bus.frame_req = 1'b1;
        bus.load_bit  = fmt;
        step();
        bus.frame_req = 1'b0;
        for (int c = 1; c <= dc; c++) begin
            if (noise) begin
                bus.load_bit  = 3'($urandom);
                bus.frame_req = (c < dc) ? 1'($urandom) : 1'b0;
            end
            exp_ctl = {c < dc, c == dc,
                       (c == FG + 1 && got[0]) || (nw == 2 && c == 2 * (FG + 1) && got[1])};
            check({tag, " busy/done/pop"},
                  32'({bus.busy, bus.done, bus.read_enable_tx}), 32'(exp_ctl));
            if (c == dc - 1) begin
                check({tag, " f1 hold"}, 32'(bus.data_f1), 32'(last_f1));
                check({tag, " f2 hold"}, 32'(bus.data_f2), 32'(last_f2));
            end
            if (c == dc) begin
                check({tag, " f1"}, 32'(bus.data_f1), 32'(ef1));
                check({tag, " f2"}, 32'(bus.data_f2), 32'(ef2));
                check({tag, " underflow"}, 32'(bus.underflow), 32'(exp_uf));
            end
            step();
        end
        bus.frame_req = 1'b0;
        last_f1 = ef1;
        last_f2 = ef2;
    endtask

    task automatic clear_uf(input string tag);
        bus.underflow_clr = 1'b1;
        step();
        bus.underflow_clr = 1'b0;
        check({tag, " underflow cleared"}, 32'(bus.underflow), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ef1;
        logic [11:0] ef2;
        int          nw;
        bit [1:0]    got;
        int          pops0;
        localparam int P = FG + 2;

        tbl[0] = '{3'b001, 2, 12'hABC, 12'h123, 16'h0ABC, 12'h123, 1'b0};
        tbl[1] = '{3'b111, 2, 12'hFED, 12'hCBA, 16'hFEDC, 12'h0BA, 1'b0};
        tbl[2] = '{3'b110, 2, 12'hFED, 12'hCBA, 16'h3FB7, 12'h0BA, 1'b0};
        tbl[3] = '{3'b010, 1, 12'h5A5, 12'h000, 16'h05A5, 12'h000, 1'b0};
        tbl[4] = '{3'b011, 0, 12'h000, 12'h000, HOLD ? 16'h05A5 : 16'h0000, 12'h000, 1'b1};
        tbl[5] = '{3'b001, 1, 12'h777, 12'h000, 16'h0777, HOLD ? 12'hCBA : 12'h000, 1'b1};

        clear_hist();
        bus.frame_req     = 1'b0;
        bus.load_bit      = 3'b000;
        bus.underflow_clr = 1'b0;
        reset_tx          = 1'b1;
        drive_fifo();
        repeat (3) step();
        check("reset ctl", 32'({bus.busy, bus.done, bus.read_enable_tx, bus.underflow}), 32'd0);
        check("reset f1", 32'(bus.data_f1), 32'd0);
        check("reset f2", 32'(bus.data_f2), 32'd0);
        reset_tx = 1'b0;
        step();

        // Format 000 is ignored entirely.
        fifo.push_back(12'h111);
        drive_fifo();
        bus.frame_req = 1'b1;
        bus.load_bit  = 3'b000;
        step();
        bus.frame_req = 1'b0;
        for (int c = 1; c <= 2 * P; c++) begin
            check("fmt000 idle", 32'({bus.busy, bus.done, bus.read_enable_tx}), 32'd0);
            step();
        end
        check("fmt000 fifo untouched", 32'(fifo.size()), 32'd1);
        fifo.delete();
        drive_fifo();

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].nwords > 0) fifo.push_back(tbl[i].wa);
            if (tbl[i].nwords > 1) fifo.push_back(tbl[i].wb);
            drive_fifo();
            model_frame(tbl[i].fmt, ef1, ef2, nw, got);
            run_frame($sformatf("vec%0d", i), tbl[i].fmt, tbl[i].f1, tbl[i].f2, nw, got,
                      tbl[i].uf, 1'b0);
            check($sformatf("vec%0d fifo drained", i), 32'(fifo.size()), 32'd0);
            clear_uf($sformatf("vec%0d", i));
        end

        // Clear coinciding with an underflow set: the set wins.
        model_frame(3'b011, ef1, ef2, nw, got);
        bus.frame_req = 1'b1;
        bus.load_bit  = 3'b011;
        step();
        bus.frame_req = 1'b0;
        for (int c = 1; c <= FG + 1; c++) begin
            if (c == FG + 1) bus.underflow_clr = 1'b1;
            step();
        end
        bus.underflow_clr = 1'b0;
        check("clr-vs-set done", 32'(bus.done), 32'd1);
        check("clr-vs-set underflow", 32'(bus.underflow), 32'd1);
        check("clr-vs-set f1", 32'(bus.data_f1), 32'(ef1));
        last_f1 = ef1;
        last_f2 = ef2;
        step();
        check("clr-vs-set sticky", 32'(bus.underflow), 32'd1);
        clear_uf("clr-vs-set");

        // Reset in cycle 4 of a two-word frame aborts it.
        fifo.push_back(12'h321);
        fifo.push_back(12'h654);
        drive_fifo();
        pops0 = n_pops;
        bus.frame_req = 1'b1;
        bus.load_bit  = 3'b001;
        step();
        bus.frame_req = 1'b0;
        repeat (3) step();
        reset_tx = 1'b1;
        step();
        reset_tx = 1'b0;
        check("midreset ctl", 32'({bus.busy, bus.done, bus.read_enable_tx, bus.underflow}), 32'd0);
        check("midreset f1", 32'(bus.data_f1), 32'd0);
        check("midreset f2", 32'(bus.data_f2), 32'd0);
        for (int c = 0; c < 3 * P; c++) begin
            check("midreset quiet", 32'({bus.busy, bus.done, bus.read_enable_tx}), 32'd0);
            step();
        end
        check("midreset no pop", 32'(n_pops - pops0), 32'd0);
        fifo.delete();
        drive_fifo();
        clear_hist();
        last_f1 = '0;
        last_f2 = '0;

        // Level request held high: one single-word frame every FG+2 cycles.
        for (int k = 0; k < 3; k++) fifo.push_back(12'($urandom));
        drive_fifo();
        pops0 = n_pops;
        bus.frame_req = 1'b1;
        bus.load_bit  = 3'b010;
        model_frame(3'b010, ef1, ef2, nw, got);
        step();
        for (int c = 1; c <= 3 * P; c++) begin
            check("b2b busy/done/pop", 32'({bus.busy, bus.done, bus.read_enable_tx}),
                  32'({c % P != 0, c % P == 0, c % P == P - 1}));
            if (c % P == 0) begin
                check("b2b f1", 32'(bus.data_f1), 32'(ef1));
                check("b2b f2", 32'(bus.data_f2), 32'(ef2));
                last_f1 = ef1;
                last_f2 = ef2;
                if (c < 3 * P) model_frame(3'b010, ef1, ef2, nw, got);
                else bus.frame_req = 1'b0;
            end
            step();
        end
        check("b2b pop count", 32'(n_pops - pops0), 32'd3);
        for (int c = 0; c < P; c++) begin
            check("b2b stop", 32'({bus.busy, bus.done, bus.read_enable_tx}), 32'd0);
            step();
        end

        // Random frames against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] fmt;
            int         nfill;
            bit         exp_uf;
            fmt   = 3'($urandom_range(7, 1));
            nfill = $urandom_range(2, 0);
            for (int k = 0; k < nfill; k++) begin
                if (fifo.size() < 3) fifo.push_back(12'($urandom));
            end
            drive_fifo();
            model_frame(fmt, ef1, ef2, nw, got);
            exp_uf = !got[0] || (nw == 2 && !got[1]);
            run_frame($sformatf("rnd%0d", i), fmt, ef1, ef2, nw, got, exp_uf, 1'b1);
            clear_uf($sformatf("rnd%0d", i));
            repeat ($urandom_range(2, 0)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
